input_conditioner: RTL
======================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the number of synchroniser flops per raw input bit (legal 2..4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), is the number of consecutive stable cycles required before a debounced button changes (legal 2..2^24).
REQ-003 Parameter BTN_ACTIVE_LOW, default 1, is 1 when a released button reads 1 and a pressed button reads 0.
REQ-004 Port clk, input, 1, is the single system clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, is the reset; it is synchronous and active-high.
REQ-006 Port sw_raw, input, 32, carries the asynchronous board switch levels.
REQ-007 Port btn_raw, input, 4, carries the asynchronous, bouncing board button levels.
REQ-008 Port io_sw, output, 32, carries the synchronised switch levels that feed the load/store unit's switch input.
REQ-009 Port io_btn, output, 4, carries the debounced button levels that feed the load/store unit's button input, with raw polarity preserved.
REQ-010 Port btn_press, output, 4, carries a one-cycle pulse per button on each debounced press.
REQ-011 Port btn_release, output, 4, carries a one-cycle pulse per button on each debounced release.

Function
REQ-012 Each sw_raw bit SHALL pass through a SYNC_STAGES flop chain; io_sw is the last stage, so a raw change sampled at edge n appears on io_sw after edge n+SYNC_STAGES-1.
REQ-013 Switches SHALL NOT be debounced.
REQ-014 Each btn_raw bit SHALL pass through its own SYNC_STAGES chain; the last stage is called btn_s.
REQ-015 Each button SHALL own a counter of ceil(log2(DEBOUNCE_CYCLES)) bits and a debounced level io_btn[i].
REQ-016 Each button SHALL have two states: STABLE and PENDING.
REQ-017 In STABLE, when btn_s != io_btn[i], the button SHALL go to PENDING with count = 1.
REQ-018 In PENDING, when btn_s == io_btn[i] (a bounce), the button SHALL go to STABLE with count = 0 and io_btn unchanged.
REQ-019 In PENDING, when btn_s != io_btn[i] and count == DEBOUNCE_CYCLES-1, the button SHALL toggle io_btn[i], clear count and return to STABLE.
REQ-020 In PENDING otherwise, count SHALL increment by 1 and SHALL never wrap.
REQ-021 io_btn[i] SHALL therefore change exactly DEBOUNCE_CYCLES edges after btn_s first differs continuously.
REQ-022 btn_press[i] SHALL pulse high for exactly the cycle after io_btn[i] moves from released to pressed level; btn_release[i] SHALL behave the same for pressed to released.
REQ-023 btn_press and btn_release for one button SHALL never be high in the same cycle; different buttons are fully independent and may pulse simultaneously.
REQ-024 A raw glitch shorter than DEBOUNCE_CYCLES cycles, measured at btn_s, SHALL never change io_btn or generate a pulse.

Reset
REQ-025 While rst is high at a clock edge, all switch synchroniser flops and io_sw SHALL clear to 0.
REQ-026 While rst is high at a clock edge, all button synchroniser flops and io_btn SHALL load the released level (4'hF when BTN_ACTIVE_LOW=1, else 4'h0).
REQ-027 While rst is high at a clock edge, counters SHALL clear, states SHALL go to STABLE, and btn_press and btn_release SHALL be 0.
REQ-028 Reset asserted during PENDING SHALL abort the pending change with no pulse, and no pulse SHALL occur on the first cycle after reset deasserts.

Structure
REQ-029 SYNC_STAGES and DEBOUNCE_CYCLES defaults and the debounce state enum {STABLE, PENDING} SHALL reside in the shared package io_pkg.
REQ-030 The per-button logic SHALL be sub-module debounce_cell (synchroniser, FSM, counter, edge pulses), instantiated 4 times; the switch synchronisers SHALL be inline.

Verification (bench uses DEBOUNCE_CYCLES=8, SYNC_STAGES=2, BTN_ACTIVE_LOW=1)
REQ-031 Reset test: assert rst for 3 cycles with btn_raw=4'h0 and sw_raw=32'hFFFF_FFFF -> during reset io_btn=4'hF, io_sw=0, no pulses; after release io_sw=32'hFFFF_FFFF two edges later.
REQ-032 Clean press test: btn_raw[0] goes 1->0 and is held -> io_btn[0]=0 exactly 2+8 edges after the change, then btn_press[0] is high for one cycle.
REQ-033 Bounce test: btn_raw[1] toggles 0/1 every 3 cycles for 30 cycles, then holds 1 -> io_btn[1] stays 1 and btn_press/btn_release stay 0.
REQ-034 Near-threshold test: btn_raw[2] is held low for 7 synced cycles then high -> no change; held low for 8 cycles -> io_btn[2]=0 with one btn_press[2] pulse.
REQ-035 Simultaneous and reset test: press buttons 0 and 3 on the same edge -> both pulses fire on the same cycle; assert rst at count=5 of a new press -> no pulse, io_btn=4'hF.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the board input conditioner: default timing
// parameters, port widths and the per-button debounce state type.
package io_pkg;

    localparam int SYNC_STAGES_DEFAULT     = 2;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;   // 10 ms at 50 MHz
    localparam int NUM_SW                  = 32;
    localparam int NUM_BTN                 = 4;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } debounce_state_e;

    // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int counter_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    function automatic logic released_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: SYNC_STAGES synchroniser, STABLE/PENDING debounce FSM with a
// saturating run counter, and registered press/release pulses.
module debounce_cell
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int             CW       = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           RELEASED = released_level(BTN_ACTIVE_LOW);

    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_s;
    debounce_state_e        state;
    logic [CW-1:0]          count;

    assign btn_s = sync[SYNC_STAGES-1];

    // Pulses are registered in the same branch that toggles level, so a
    // pulse is visible exactly during the first cycle of the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync          <= {SYNC_STAGES{RELEASED}};
            state         <= STABLE;
            count         <= '0;
            level         <= RELEASED;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync          <= {sync[SYNC_STAGES-2:0], raw};
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                STABLE: begin
                    if (btn_s != level) begin
                        state <= PENDING;
                        count <= CW'(1);
                    end
                end
                PENDING: begin
                    if (btn_s == level) begin
                        state <= STABLE;
                        count <= '0;
                    end else if (count == LAST) begin
                        level <= ~level;
                        state <= STABLE;
                        count <= '0;
                        if (level == RELEASED) begin
                            press_pulse <= 1'b1;
                        end else begin
                            release_pulse <= 1'b1;
                        end
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state <= STABLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: synchronised (not debounced) switches and four
// synchronised, debounced buttons with press/release pulses.
module input_conditioner
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SW-1:0]  sw_raw,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_SW-1:0]  io_sw,
    output logic [NUM_BTN-1:0] io_btn,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    logic [NUM_SW-1:0] sw_sync [SYNC_STAGES];

    // NOTE: non-blocking so each stage captures its predecessor's pre-edge
    // value; blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sw_sync[s] <= '0;
            end
        end else begin
            sw_sync[0] <= sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sw_sync[s] <= sw_sync[s-1];
            end
        end
    end

    assign io_sw = sw_sync[SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_cell #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_cell (
            .clk           (clk),
            .rst           (rst),
            .raw           (btn_raw[i]),
            .level         (io_btn[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i])
        );
    end

endmodule
